// File: rtl/serial_nibble_loader.sv
// serial_nibble_loader
//   Serial-to-parallel front end: collects a framed serial bit stream into a
//   WIDTH-bit word for the downstream 4-bit D-register stage.
//
//   Optional feature macro: SER_PARITY_EN
//     defined   -> a trailing even-parity bit follows each frame; perr reports it
//     undefined -> frames are exactly WIDTH data bits; perr is tied low
//
//   Parameters:
//     WIDTH      data bits per frame (>= 2)
//     MSB_FIRST  1: first received bit lands in word[WIDTH-1]; 0: in word[0]
//
//   Ports:
//     clk         clock, rising edge
//     rst         asynchronous, active-high reset
//     start       one-cycle frame-start strobe (aborts a frame in progress)
//     sin         serial data bit
//     sin_valid   qualifies sin; a bit is taken only when this is 1
//     word        last completed word, held until the next completion
//     word_valid  one-cycle pulse, word updated this cycle
//     busy        1 while a frame is in progress
//     perr        parity error, pulses with word_valid (parity build only)
module serial_nibble_loader #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             busy,
  output logic             perr
);

  localparam int unsigned     CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wv_q, wv_d;
  logic [WIDTH-1:0] shifted;

  // Shift register with the current sin folded in, in the configured order.
  always_comb begin
    if (MSB_FIRST) shifted = {shreg_q[WIDTH-2:0], sin};
    else           shifted = {sin, shreg_q[WIDTH-1:1]};
  end

`ifdef SER_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    wv_d    = 1'b0;
`ifdef SER_PARITY_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        // start outranks a simultaneous data bit: the frame restarts cleanly.
        if (start) begin
          cnt_d   = '0;
          shreg_d = '0;
        end else if (sin_valid) begin
          shreg_d = shifted;
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
`ifdef SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            word_d  = shifted;
            wv_d    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (sin_valid) begin
          // Even parity: data ones plus p must be even, else flag.
          state_d = IDLE;
          word_d  = shreg_q;
          wv_d    = 1'b1;
          perr_d  = (^shreg_q) ^ sin;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign word       = word_q;
  assign word_valid = wv_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_nibble_loader.sv
// tb_serial_nibble_loader
//   Drives two loaders (MSB-first and LSB-first, WIDTH=4) from shared inputs.
//   Expected {perr, word} values are queued when a frame is sent and popped
//   when word_valid is sampled. Inputs change on the falling edge; outputs are
//   sampled 2 time units after the rising edge.
module tb_serial_nibble_loader;

  logic       clk, rst, start, sin, sin_valid;
  logic [3:0] word_m, word_l;
  logic       wv_m, wv_l, busy_m, busy_l, perr_m, perr_l;

  int n_checks = 0;
  int n_pass   = 0;
  int nwv_m    = 0;
  int nwv_l    = 0;
  bit perr_seen = 1'b0;

  logic [4:0] exp_m[$];
  logic [4:0] exp_l[$];

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
    .word(word_m), .word_valid(wv_m), .busy(busy_m), .perr(perr_m)
  );

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
    .word(word_l), .word_valid(wv_l), .busy(busy_l), .perr(perr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wv_m === 1'b1) nwv_m++;
    if (wv_l === 1'b1) nwv_l++;
    if (perr_m === 1'b1 || perr_l === 1'b1) perr_seen = 1'b1;
  end

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

  // Drive-only helpers; every comparison lives in the test tasks.
  task automatic drive_start();
    @(negedge clk);
    start = 1'b1; sin_valid = 1'b1; sin = 1'b1;
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    start = 1'b0; sin_valid = 1'b1; sin = b;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; sin_valid = 1'b0; sin = 1'($urandom_range(0, 1));
    end
  endtask

  // seq[3] is the first bit on the wire; bad=1 sends a wrong parity bit.
  task automatic send_frame(input logic [3:0] seq, input logic bad);
    drive_start();
    for (int i = 3; i >= 0; i--) drive_bit(seq[i]);
`ifdef SER_PARITY_EN
    drive_bit((^seq) ^ bad);
`endif
  endtask

  task automatic test_reset();
    logic [4:0] z;
    z = '0;
    repeat (3) begin
      @(negedge clk);
      start = 1'b1; sin_valid = 1'b1; sin = 1'b1;
    end
    @(posedge clk); #2;
    n_checks++; if ({perr_m, word_m} !== z) $display("FAIL reset_word_m: got %b expected %b", {perr_m, word_m}, z); else n_pass++;
    n_checks++; if ({perr_l, word_l} !== z) $display("FAIL reset_word_l: got %b expected %b", {perr_l, word_l}, z); else n_pass++;
    n_checks++; if ({wv_m, wv_l} !== 2'b00) $display("FAIL reset_wv: got %b expected 00", {wv_m, wv_l}); else n_pass++;
    n_checks++; if ({busy_m, busy_l} !== 2'b00) $display("FAIL reset_busy: got %b expected 00", {busy_m, busy_l}); else n_pass++;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; sin_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] seq;
    logic [4:0] e;
    seq = 4'b1011;
    exp_m.push_back({1'b0, seq});
    exp_l.push_back({1'b0, rev4(seq)});
    drive_start();
    @(posedge clk); #2;
    n_checks++; if ({busy_m, wv_m} !== 2'b10) $display("FAIL basic_busy_start: got %b expected 10", {busy_m, wv_m}); else n_pass++;
    for (int i = 3; i >= 1; i--) begin
      drive_bit(seq[i]);
      @(posedge clk); #2;
      n_checks++; if ({busy_m, wv_m} !== 2'b10) $display("FAIL basic_busy_bit%0d: got %b expected 10", 3 - i, {busy_m, wv_m}); else n_pass++;
    end
    drive_bit(seq[0]);
`ifdef SER_PARITY_EN
    @(posedge clk); #2;
    n_checks++; if ({busy_m, wv_m} !== 2'b10) $display("FAIL basic_busy_parity: got %b expected 10", {busy_m, wv_m}); else n_pass++;
    drive_bit(^seq);
`endif
    @(posedge clk); #2;
    n_checks++; if ({wv_m, wv_l} !== 2'b11) $display("FAIL basic_wv: got %b expected 11", {wv_m, wv_l}); else n_pass++;
    e = exp_m.pop_front();
    n_checks++; if ({perr_m, word_m} !== e) $display("FAIL basic_word_m: got %b expected %b", {perr_m, word_m}, e); else n_pass++;
    e = exp_l.pop_front();
    n_checks++; if ({perr_l, word_l} !== e) $display("FAIL basic_word_l: got %b expected %b", {perr_l, word_l}, e); else n_pass++;
    drive_idle(1);
    @(posedge clk); #2;
    n_checks++; if ({wv_m, busy_m, word_m} !== {2'b00, seq}) $display("FAIL basic_hold: got %b expected %b", {wv_m, busy_m, word_m}, {2'b00, seq}); else n_pass++;
    drive_idle(2);
  endtask

  task automatic test_back_to_back();
    logic [3:0] s1, s2;
    logic [4:0] e;
    int c0;
    s1 = 4'b1011; s2 = 4'b0001;
    c0 = nwv_l;
    exp_m.push_back({1'b0, s1}); exp_l.push_back({1'b0, rev4(s1)});
    send_frame(s1, 1'b0);
    @(posedge clk); #2;
    e = exp_l.pop_front();
    n_checks++; if ({wv_l, perr_l, word_l} !== {1'b1, e}) $display("FAIL b2b_first_l: got %b expected %b", {wv_l, perr_l, word_l}, {1'b1, e}); else n_pass++;
    e = exp_m.pop_front();
    n_checks++; if ({wv_m, perr_m, word_m} !== {1'b1, e}) $display("FAIL b2b_first_m: got %b expected %b", {wv_m, perr_m, word_m}, {1'b1, e}); else n_pass++;
    // Next start lands on the falling edge of the word_valid cycle.
    exp_m.push_back({1'b0, s2}); exp_l.push_back({1'b0, rev4(s2)});
    send_frame(s2, 1'b0);
    @(posedge clk); #2;
    e = exp_l.pop_front();
    n_checks++; if ({wv_l, perr_l, word_l} !== {1'b1, e}) $display("FAIL b2b_second_l: got %b expected %b", {wv_l, perr_l, word_l}, {1'b1, e}); else n_pass++;
    e = exp_m.pop_front();
    n_checks++; if ({wv_m, perr_m, word_m} !== {1'b1, e}) $display("FAIL b2b_second_m: got %b expected %b", {wv_m, perr_m, word_m}, {1'b1, e}); else n_pass++;
    drive_idle(2);
    n_checks++; if (nwv_l - c0 !== 2) $display("FAIL b2b_pulses: got %0d expected 2", nwv_l - c0); else n_pass++;
  endtask

  task automatic test_stall();
    logic [3:0] seq;
    logic [4:0] e;
    int c0;
    seq = 4'b1100;
    c0 = nwv_m;
    exp_m.push_back({1'b0, seq}); exp_l.push_back({1'b0, rev4(seq)});
    drive_start();
    for (int b = 3; b >= 0; b--) begin
      drive_bit(seq[b]);
      if (b >= 2) begin
        for (int g = 0; g < 3; g++) begin
          drive_idle(1);
          @(posedge clk); #2;
          n_checks++; if ({busy_m, wv_m, wv_l} !== 3'b100) $display("FAIL stall_gap_b%0d_c%0d: got %b expected 100", 3 - b, g, {busy_m, wv_m, wv_l}); else n_pass++;
        end
      end
    end
`ifdef SER_PARITY_EN
    drive_bit(^seq);
`endif
    @(posedge clk); #2;
    e = exp_m.pop_front();
    n_checks++; if ({wv_m, perr_m, word_m} !== {1'b1, e}) $display("FAIL stall_word_m: got %b expected %b", {wv_m, perr_m, word_m}, {1'b1, e}); else n_pass++;
    e = exp_l.pop_front();
    n_checks++; if ({wv_l, perr_l, word_l} !== {1'b1, e}) $display("FAIL stall_word_l: got %b expected %b", {wv_l, perr_l, word_l}, {1'b1, e}); else n_pass++;
    drive_idle(2);
    n_checks++; if (nwv_m - c0 !== 1) $display("FAIL stall_pulses: got %0d expected 1", nwv_m - c0); else n_pass++;
  endtask

  task automatic test_abort();
    logic [3:0] seq, prev;
    logic [4:0] e;
    int c0;
    seq = 4'b0101; prev = word_m;
    c0 = nwv_m;
    drive_start();
    drive_bit(1'b1);
    drive_bit(1'b1);
    exp_m.push_back({1'b0, seq}); exp_l.push_back({1'b0, rev4(seq)});
    // drive_start also presents sin_valid=1/sin=1, which must be ignored.
    send_frame(seq, 1'b0);
    @(posedge clk); #2;
    e = exp_m.pop_front();
    n_checks++; if ({wv_m, perr_m, word_m} !== {1'b1, e}) $display("FAIL abort_word_m: got %b expected %b", {wv_m, perr_m, word_m}, {1'b1, e}); else n_pass++;
    e = exp_l.pop_front();
    n_checks++; if ({wv_l, perr_l, word_l} !== {1'b1, e}) $display("FAIL abort_word_l: got %b expected %b", {wv_l, perr_l, word_l}, {1'b1, e}); else n_pass++;
    drive_idle(2);
    n_checks++; if (nwv_m - c0 !== 1) $display("FAIL abort_pulses: got %0d expected 1", nwv_m - c0); else n_pass++;
    n_checks++; if (prev !== 4'b1100) $display("FAIL abort_prev_word: got %b expected 1100", prev); else n_pass++;
  endtask

  task automatic test_abort_hold();
    // Word must stay put while an aborted and a restarted frame are in flight.
    logic [3:0] prev;
    prev = word_m;
    drive_start();
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_start();
    drive_bit(1'b0);
    @(posedge clk); #2;
    n_checks++; if ({wv_m, word_m} !== {1'b0, prev}) $display("FAIL abort_hold: got %b expected %b", {wv_m, word_m}, {1'b0, prev}); else n_pass++;
    drive_idle(1);
    // Leave the frame pending; the reset test below discards it.
  endtask

  task automatic test_reset_midframe();
    logic [3:0] seq;
    logic [4:0] e;
    int c0;
    seq = 4'b0110;
    c0 = nwv_m;
    drive_start();
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++; if ({word_m, word_l} !== 8'h00) $display("FAIL rstmid_word: got %h expected 00", {word_m, word_l}); else n_pass++;
    n_checks++; if ({busy_m, busy_l, wv_m, perr_m} !== 4'b0000) $display("FAIL rstmid_ctrl: got %b expected 0000", {busy_m, busy_l, wv_m, perr_m}); else n_pass++;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; sin_valid = 1'b0;
    n_checks++; if (nwv_m - c0 !== 0) $display("FAIL rstmid_nopulse: got %0d expected 0", nwv_m - c0); else n_pass++;
    exp_m.push_back({1'b0, seq}); exp_l.push_back({1'b0, rev4(seq)});
    send_frame(seq, 1'b0);
    @(posedge clk); #2;
    e = exp_m.pop_front();
    n_checks++; if ({wv_m, perr_m, word_m} !== {1'b1, e}) $display("FAIL rstmid_after_m: got %b expected %b", {wv_m, perr_m, word_m}, {1'b1, e}); else n_pass++;
    e = exp_l.pop_front();
    n_checks++; if ({wv_l, perr_l, word_l} !== {1'b1, e}) $display("FAIL rstmid_after_l: got %b expected %b", {wv_l, perr_l, word_l}, {1'b1, e}); else n_pass++;
    drive_idle(2);
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    logic [3:0] seq, seq2;
    logic [4:0] e;
    int c0;
    seq = 4'b1011; seq2 = 4'b0110;
    exp_m.push_back({1'b0, seq}); exp_l.push_back({1'b0, rev4(seq)});
    send_frame(seq, 1'b0);
    @(posedge clk); #2;
    e = exp_m.pop_front();
    n_checks++; if ({wv_m, perr_m, word_m} !== {1'b1, e}) $display("FAIL par_good_m: got %b expected %b", {wv_m, perr_m, word_m}, {1'b1, e}); else n_pass++;
    void'(exp_l.pop_front());
    drive_idle(1);
    exp_m.push_back({1'b1, seq}); exp_l.push_back({1'b1, rev4(seq)});
    send_frame(seq, 1'b1);
    @(posedge clk); #2;
    e = exp_m.pop_front();
    n_checks++; if ({wv_m, perr_m, word_m} !== {1'b1, e}) $display("FAIL par_bad_m: got %b expected %b", {wv_m, perr_m, word_m}, {1'b1, e}); else n_pass++;
    e = exp_l.pop_front();
    n_checks++; if ({wv_l, perr_l, word_l} !== {1'b1, e}) $display("FAIL par_bad_l: got %b expected %b", {wv_l, perr_l, word_l}, {1'b1, e}); else n_pass++;
    drive_idle(1);
    @(posedge clk); #2;
    n_checks++; if ({wv_m, perr_m} !== 2'b00) $display("FAIL par_perr_pulse: got %b expected 00", {wv_m, perr_m}); else n_pass++;
    // Abort while waiting for the parity bit.
    c0 = nwv_m;
    drive_start();
    for (int i = 3; i >= 0; i--) drive_bit(seq[i]);
    exp_m.push_back({1'b0, seq2}); exp_l.push_back({1'b0, rev4(seq2)});
    send_frame(seq2, 1'b0);
    @(posedge clk); #2;
    e = exp_m.pop_front();
    n_checks++; if ({wv_m, perr_m, word_m} !== {1'b1, e}) $display("FAIL par_abort_m: got %b expected %b", {wv_m, perr_m, word_m}, {1'b1, e}); else n_pass++;
    void'(exp_l.pop_front());
    drive_idle(2);
    n_checks++; if (nwv_m - c0 !== 1) $display("FAIL par_abort_pulses: got %0d expected 1", nwv_m - c0); else n_pass++;
  endtask
`else
  task automatic test_parity();
    n_checks++; if (perr_seen !== 1'b0) $display("FAIL perr_tied: got %b expected 0", perr_seen); else n_pass++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_abort();
    test_abort_hold();
    test_reset_midframe();
    test_parity();
    n_checks++; if (exp_m.size() + exp_l.size() !== 0) $display("FAIL scoreboard_empty: got %0d expected 0", exp_m.size() + exp_l.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
